// File: rtl/memory_arbiter.sv
// Two-port (I-cache / D-cache) arbiter in front of a single line-wide backing memory.
// Define MEMORY_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; the default gives the data cache fixed priority.
module memory_arbiter #(
   parameter int ADDRESS_SIZE    = 12,
   parameter int CACHE_LINE_SIZE = 128
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       req0_valid,
   input  logic                       req0_op,
   input  logic [ADDRESS_SIZE-1:0]    req0_address,
   input  logic [CACHE_LINE_SIZE-1:0] req0_data_in,
   input  logic                       req1_valid,
   input  logic                       req1_op,
   input  logic [ADDRESS_SIZE-1:0]    req1_address,
   input  logic [CACHE_LINE_SIZE-1:0] req1_data_in,
   output logic                       req0_accept,
   output logic                       req1_accept,
   output logic                       req0_done,
   output logic                       req1_done,
   output logic [CACHE_LINE_SIZE-1:0] resp_data,
   output logic                       mem_enable,
   output logic                       mem_op,
   output logic                       mem_op_init,
   output logic                       mem_op_done,
   output logic [ADDRESS_SIZE-1:0]    mem_address,
   output logic [CACHE_LINE_SIZE-1:0] mem_data_in,
   input  logic [CACHE_LINE_SIZE-1:0] mem_data_out,
   input  logic                       mem_data_ready
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

   state_t                     state_q, state_d;
   logic                       grant;
   logic                       pick;
   logic                       memDone;
   logic                       winner_q;
   logic                       accept0_q, accept1_q;
   logic                       done0_q, done1_q;
   logic                       memOpDone_q;
   logic                       memOp_q;
   logic [ADDRESS_SIZE-1:0]    memAddress_q;
   logic [CACHE_LINE_SIZE-1:0] memDataIn_q;
   logic [CACHE_LINE_SIZE-1:0] respData_q;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
   logic                       lastGrant_q;
`endif

   // pick = 1 selects port 1; only meaningful while grant is high
   always_comb begin
      grant = (state_q == IDLE) && (req0_valid || req1_valid);
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
      pick = (req0_valid && req1_valid) ? ~lastGrant_q : req1_valid;
`else
      pick = req1_valid;
`endif
   end

   always_comb begin
      state_d = state_q;
      memDone = 1'b0;
      case (state_q)
         IDLE:    if (grant) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT: begin
            if (mem_data_ready) begin
               memDone = 1'b1;
               state_d = RELEASE;
            end
         end
         RELEASE: if (!mem_data_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         winner_q     <= 1'b0;
         accept0_q    <= 1'b0;
         accept1_q    <= 1'b0;
         done0_q      <= 1'b0;
         done1_q      <= 1'b0;
         memOpDone_q  <= 1'b0;
         memOp_q      <= 1'b0;
         memAddress_q <= '0;
         memDataIn_q  <= '0;
         respData_q   <= '0;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
         lastGrant_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         accept0_q   <= grant && !pick;
         accept1_q   <= grant && pick;
         done0_q     <= memDone && !winner_q;
         done1_q     <= memDone && winner_q;
         memOpDone_q <= memDone;
         if (grant) begin
            winner_q     <= pick;
            memOp_q      <= pick ? req1_op      : req0_op;
            memAddress_q <= pick ? req1_address : req0_address;
            memDataIn_q  <= pick ? req1_data_in : req0_data_in;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            lastGrant_q  <= pick;
`endif
         end
         if (memDone && !memOp_q) respData_q <= mem_data_out;
      end
   end

   assign req0_accept = accept0_q;
   assign req1_accept = accept1_q;
   assign req0_done   = done0_q;
   assign req1_done   = done1_q;
   assign mem_op_done = memOpDone_q;
   assign mem_op      = memOp_q;
   assign mem_address = memAddress_q;
   assign mem_data_in = memDataIn_q;
   assign resp_data   = respData_q;
   assign mem_op_init = (state_q == ISSUE);
   assign mem_enable  = (state_q == ISSUE) || ((state_q == WAIT) && !mem_data_ready);

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomised bench for memory_arbiter: a behavioural memory responder plus a transaction-level
// reference model that predicts the winner, memory fields, done port and returned line.
module tb_memory_arbiter;

   localparam int AW = 12;
   localparam int LW = 128;

   logic          clk = 1'b0;
   logic          reset;
   logic          req0_valid, req0_op, req1_valid, req1_op;
   logic [AW-1:0] req0_address, req1_address;
   logic [LW-1:0] req0_data_in, req1_data_in;
   logic          req0_accept, req1_accept, req0_done, req1_done;
   logic [LW-1:0] resp_data;
   logic          mem_enable, mem_op, mem_op_init, mem_op_done;
   logic [AW-1:0] mem_address;
   logic [LW-1:0] mem_data_in;
   logic [LW-1:0] mem_data_out;
   logic          mem_data_ready;

   always #5 clk = ~clk;

   memory_arbiter #(.ADDRESS_SIZE(AW), .CACHE_LINE_SIZE(LW)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_op(req0_op), .req0_address(req0_address), .req0_data_in(req0_data_in),
      .req1_valid(req1_valid), .req1_op(req1_op), .req1_address(req1_address), .req1_data_in(req1_data_in),
      .req0_accept(req0_accept), .req1_accept(req1_accept),
      .req0_done(req0_done), .req1_done(req1_done),
      .resp_data(resp_data),
      .mem_enable(mem_enable), .mem_op(mem_op), .mem_op_init(mem_op_init), .mem_op_done(mem_op_done),
      .mem_address(mem_address), .mem_data_in(mem_data_in),
      .mem_data_out(mem_data_out), .mem_data_ready(mem_data_ready)
   );

   // Backing store seen by the responder, and the model's independent copy of it
   logic [LW-1:0] memArr [0:4095];
   logic [LW-1:0] refMem [0:4095];

   int            forceLat = 0;
   int            checkCount = 0;
   int            passCount = 0;
   logic          allowWithdraw = 1'b0;

   logic          pendV    [2];
   logic          pendOp   [2];
   logic [AW-1:0] pendAddr [2];
   logic [LW-1:0] pendData [2];

   logic          lastGrant;
   logic [LW-1:0] expResp;
   logic          curRead;
   logic [LW-1:0] curLine;

   task automatic checkOutput(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      checkCount++;
      if (obs === exp) passCount++;
      else $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
   endtask

   task automatic driveReqs();
      req0_valid = pendV[0]; req0_op = pendOp[0]; req0_address = pendAddr[0]; req0_data_in = pendData[0];
      req1_valid = pendV[1]; req1_op = pendOp[1]; req1_address = pendAddr[1]; req1_data_in = pendData[1];
   endtask

   task automatic applyStimulus(input int port, input logic op, input logic [AW-1:0] addr, input logic [LW-1:0] data);
      pendV[port] = 1'b1; pendOp[port] = op; pendAddr[port] = addr; pendData[port] = data;
      driveReqs();
   endtask

   task automatic waitAccept(output int winner, output logic ok);
      int   expWin;
      logic got;
      got = 1'b0;
      if (pendV[0] && pendV[1]) begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
         expWin = lastGrant ? 0 : 1;
`else
         expWin = 1;
`endif
      end else begin
         expWin = pendV[1] ? 1 : 0;
      end
      for (int c = 0; c < 16; c++) begin
         @(posedge clk); #1;
         if (req0_accept || req1_accept) begin
            got = 1'b1;
            break;
         end
      end
      checkOutput("acceptSeen", LW'(got), LW'(1));
      if (got) begin
         checkOutput("acceptPort", LW'({req1_accept, req0_accept}), (expWin == 1) ? LW'(2) : LW'(1));
         checkOutput("memOpInit", LW'(mem_op_init), LW'(1));
         checkOutput("memEnableIssue", LW'(mem_enable), LW'(1));
         checkOutput("memAddress", LW'(mem_address), LW'(pendAddr[expWin]));
         checkOutput("memOp", LW'(mem_op), LW'(pendOp[expWin]));
         checkOutput("memDataIn", mem_data_in, pendData[expWin]);
         lastGrant = (expWin == 1);
         curRead = !pendOp[expWin];
         curLine = refMem[pendAddr[expWin]];
         if (pendOp[expWin]) refMem[pendAddr[expWin]] = pendData[expWin];
         pendV[expWin] = 1'b0;
         if (allowWithdraw && pendV[1-expWin] && $urandom_range(0, 3) == 0) pendV[1-expWin] = 1'b0;
         driveReqs();
      end
      winner = expWin;
      ok = got;
   endtask

   task automatic waitDone(input int winner);
      logic got, busyAcc;
      got = 1'b0; busyAcc = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (req0_accept || req1_accept) busyAcc = 1'b1;
         if (req0_done || req1_done) begin
            got = 1'b1;
            break;
         end
      end
      checkOutput("noAcceptBusy", LW'(busyAcc), LW'(0));
      checkOutput("doneSeen", LW'(got), LW'(1));
      if (got) begin
         if (curRead) expResp = curLine;
         checkOutput("donePort", LW'({req1_done, req0_done}), (winner == 1) ? LW'(2) : LW'(1));
         checkOutput("memOpDone", LW'(mem_op_done), LW'(1));
         checkOutput("respData", resp_data, expResp);
         checkOutput("memEnableRelease", LW'(mem_enable), LW'(0));
         @(posedge clk); #1;
         checkOutput("doneOnce", LW'({req1_done, req0_done, mem_op_done}), LW'(0));
      end
   endtask

   task automatic runOp();
      int   w;
      logic ok;
      waitAccept(w, ok);
      if (ok) waitDone(w);
   endtask

   // Memory responder: random latency after mem_op_init, holds ready for a random time, aborts on reset
   initial begin
      logic          op, aborted;
      logic [AW-1:0] addr;
      logic [LW-1:0] wd;
      int            lat, hold, n;
      mem_data_ready = 1'b0;
      mem_data_out   = '0;
      forever begin
         @(posedge clk); #1;
         if (!reset && mem_op_init) begin
            op = mem_op; addr = mem_address; wd = mem_data_in;
            lat = (forceLat != 0) ? forceLat : int'($urandom_range(1, 4));
            aborted = 1'b0;
            n = 0;
            while (n < lat) begin
               @(posedge clk); #1; n++;
               if (reset) begin aborted = 1'b1; break; end
            end
            if (!aborted) begin
               if (op) memArr[addr] = wd;
               else mem_data_out = memArr[addr];
               mem_data_ready = 1'b1;
               hold = $urandom_range(1, 3);
               n = 0;
               while (n < hold) begin
                  @(posedge clk); #1; n++;
                  if (reset) break;
               end
               mem_data_ready = 1'b0;
            end
         end
      end
   end

   initial begin
      logic [LW-1:0] line;
      int            strayDone;
      for (int i = 0; i < 4096; i++) begin
         line = {$urandom, $urandom, $urandom, $urandom};
         memArr[i] = line;
         refMem[i] = line;
      end
      for (int b = 0; b < 16; b++) line[b*8 +: 8] = 8'(b);
      memArr[12'h040] = line;
      refMem[12'h040] = line;
      for (int p = 0; p < 2; p++) begin
         pendV[p] = 1'b0; pendOp[p] = 1'b0; pendAddr[p] = '0; pendData[p] = '0;
      end
      driveReqs();
      lastGrant = 1'b0; expResp = '0; curRead = 1'b0; curLine = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("resetCtl", LW'({req0_accept, req1_accept, req0_done, req1_done, mem_enable, mem_op, mem_op_init, mem_op_done}), LW'(0));
      checkOutput("resetResp", resp_data, '0);
      checkOutput("resetAddr", LW'(mem_address), LW'(0));
      checkOutput("resetDataIn", mem_data_in, '0);
      reset = 1'b0;

      $display("[TB] directed single read and write-then-read");
      applyStimulus(0, 1'b0, 12'h040, '0);
      runOp();
      applyStimulus(1, 1'b1, 12'h100, {4{32'hDEADBEEF}});
      runOp();
      applyStimulus(1, 1'b0, 12'h100, '0);
      runOp();

      $display("[TB] both ports held high back to back");
      for (int k = 0; k < 4; k++) begin
         for (int p = 0; p < 2; p++)
            if (!pendV[p]) applyStimulus(p, 1'($urandom_range(0, 1)), AW'(12'h100 + $urandom_range(0, 7)), {$urandom, $urandom, $urandom, $urandom});
         runOp();
      end

      $display("[TB] random traffic");
      allowWithdraw = 1'b1;
      for (int k = 0; k < 40; k++) begin
         for (int p = 0; p < 2; p++)
            if (!pendV[p] && $urandom_range(0, 1) == 1)
               applyStimulus(p, 1'($urandom_range(0, 1)), AW'(12'h100 + $urandom_range(0, 7)), {$urandom, $urandom, $urandom, $urandom});
         if (!pendV[0] && !pendV[1])
            applyStimulus(int'($urandom_range(0, 1)), 1'b0, AW'(12'h100 + $urandom_range(0, 7)), '0);
         runOp();
      end
      allowWithdraw = 1'b0;
      for (int p = 0; p < 2; p++) pendV[p] = 1'b0;
      driveReqs();
      repeat (6) @(posedge clk);

      $display("[TB] reset while waiting on memory");
      begin
         int   w;
         logic ok;
         forceLat = 8;
         applyStimulus(0, 1'b0, 12'h040, '0);
         waitAccept(w, ok);
         @(posedge clk); #1;
         #1 reset = 1'b1;
         @(posedge clk); #1;
         checkOutput("rstMidCtl", LW'({req0_accept, req1_accept, req0_done, req1_done, mem_enable, mem_op, mem_op_init, mem_op_done}), LW'(0));
         checkOutput("rstMidResp", resp_data, '0);
         checkOutput("rstMidAddr", LW'(mem_address), LW'(0));
         #1 reset = 1'b0;
         lastGrant = 1'b0; expResp = '0;
         strayDone = 0;
         for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (req0_done || req1_done || mem_op_done) strayDone++;
         end
         checkOutput("noDoneAfterReset", LW'(strayDone), LW'(0));
         forceLat = 0;
      end

      applyStimulus(0, 1'b0, 12'h040, '0);
      applyStimulus(1, 1'b0, 12'h100, '0);
      runOp();
      runOp();

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
